// File: rtl/nasti_wr_sequencer_pkg.sv
// Shared types for the NASTI write sequencer: FIFO transaction structs,
// burst and response encodings, and FSM states.
package nasti_wr_sequencer_pkg;

   localparam int NASTI_ID_W   = 4;
   localparam int NASTI_ADDR_W = 32;
   localparam int NASTI_DATA_W = 64;
   localparam int NASTI_USER_W = 1;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [NASTI_ID_W-1:0]   id;
      logic [NASTI_ADDR_W-1:0] addr;
      logic [7:0]              len;
      logic [2:0]              size;
      burst_t                  burst;
      logic [NASTI_USER_W-1:0] user;
   } aw_trans;

   typedef struct packed {
      logic [NASTI_DATA_W-1:0]   data;
      logic [NASTI_DATA_W/8-1:0] strb;
      logic                      last;
   } w_trans;

   typedef struct packed {
      logic [NASTI_ID_W-1:0]   id;
      logic [1:0]              resp;
      logic [NASTI_USER_W-1:0] user;
   } b_trans;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_DRAIN,
      ST_RESP
   } state_t;

   // A width parameter of 0 selects the width the shared structs are built with.
   function automatic int eff_w(input int w, input int dflt);
      return (w == 0) ? dflt : w;
   endfunction

endpackage

// File: rtl/nasti_addr_gen.sv
// Next-beat byte address for FIXED / INCR / WRAP bursts (reserved behaves as INCR).
module nasti_addr_gen
   import nasti_wr_sequencer_pkg::*;
#(
   parameter int AW = NASTI_ADDR_W
)(
   input  logic [AW-1:0] addr,
   input  logic [2:0]    size,
   input  logic [7:0]    len,
   input  burst_t        burst,
   output logic [AW-1:0] next_addr
);

   logic [AW-1:0] step;
   logic [AW-1:0] mask;
   logic [AW-1:0] incr;

   always_comb begin
      step = AW'(1) << size;
      // Wrap window is (len+1)*step bytes, aligned to its own size.
      mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
      incr = addr + step;
      unique case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
         default:     next_addr = incr;
      endcase
   end

endmodule

// File: rtl/nasti_wr_sequencer.sv
// Turns one AW burst plus its W beats into per-beat write requests and a B response.
// req handshake: a beat transfers on a cycle with req_valid & req_ready; while waiting, req_valid and addr/data/strb stay put.
module nasti_wr_sequencer
   import nasti_wr_sequencer_pkg::*;
#(
   parameter int C_NASTI_ID_WIDTH   = 0,
   parameter int C_NASTI_ADDR_WIDTH = 0,
   parameter int C_NASTI_DATA_WIDTH = 0,
   parameter int C_NASTI_USER_WIDTH = 0
)(
   input  logic    core_clk,
   input  logic    core_rst,
   input  aw_trans aw_rdata,
   input  logic    aw_rempty,
   output logic    aw_rinc,
   input  w_trans  w_rdata,
   input  logic    w_rempty,
   output logic    w_rinc,
   output b_trans  b_wdata,
   input  logic    b_wfull,
   output logic    b_winc,
   output logic    req_valid,
   input  logic    req_ready,
   output logic [eff_w(C_NASTI_ADDR_WIDTH, NASTI_ADDR_W)-1:0]   req_addr,
   output logic [eff_w(C_NASTI_DATA_WIDTH, NASTI_DATA_W)-1:0]   req_data,
   output logic [eff_w(C_NASTI_DATA_WIDTH, NASTI_DATA_W)/8-1:0] req_strb
);

   localparam int ID_EFF = eff_w(C_NASTI_ID_WIDTH, NASTI_ID_W);
   localparam int AW_EFF = eff_w(C_NASTI_ADDR_WIDTH, NASTI_ADDR_W);
   localparam int DW_EFF = eff_w(C_NASTI_DATA_WIDTH, NASTI_DATA_W);
   localparam int SW_EFF = DW_EFF / 8;
   localparam int UW_EFF = eff_w(C_NASTI_USER_WIDTH, NASTI_USER_W);

   state_t              state_q, state_d;
   logic [ID_EFF-1:0]   id_q;
   logic [UW_EFF-1:0]   user_q;
   logic [AW_EFF-1:0]   addr_q;
   logic [AW_EFF-1:0]   next_addr;
   logic [7:0]          len_q;
   logic [2:0]          size_q;
   burst_t              burst_q;
   logic [7:0]          cnt_q;
   logic                err_q;

   nasti_addr_gen #(.AW(AW_EFF)) u_addr_gen (
      .addr      (addr_q),
      .size      (size_q),
      .len       (len_q),
      .burst     (burst_q),
      .next_addr (next_addr)
   );

   always_comb begin
      state_d   = state_q;
      aw_rinc   = 1'b0;
      w_rinc    = 1'b0;
      b_winc    = 1'b0;
      req_valid = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!aw_rempty) begin
               aw_rinc = 1'b1;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            req_valid = !w_rempty;
            if (req_valid && req_ready) begin
               w_rinc = 1'b1;
               if (w_rdata.last)        state_d = ST_RESP;
               else if (cnt_q == len_q) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_rinc = !w_rempty;
            if (w_rinc && w_rdata.last) state_d = ST_RESP;
         end
         ST_RESP: begin
            b_winc = !b_wfull;
            if (b_winc) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // No FIFO strobe may fire while reset is being applied.
      if (core_rst) begin
         state_d   = ST_IDLE;
         aw_rinc   = 1'b0;
         w_rinc    = 1'b0;
         b_winc    = 1'b0;
         req_valid = 1'b0;
      end
   end

   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         state_q <= ST_IDLE;
         id_q    <= '0;
         user_q  <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= BURST_FIXED;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (aw_rinc) begin
            id_q    <= ID_EFF'(aw_rdata.id);
            user_q  <= UW_EFF'(aw_rdata.user);
            addr_q  <= AW_EFF'(aw_rdata.addr);
            len_q   <= aw_rdata.len;
            size_q  <= aw_rdata.size;
            burst_q <= aw_rdata.burst;
            cnt_q   <= '0;
            err_q   <= (aw_rdata.burst == BURST_RSVD);
         end
         if (state_q == ST_DATA && w_rinc) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= next_addr;
            // Last flag must coincide with the final beat; early or missing last is an error.
            if (w_rdata.last != (cnt_q == len_q)) err_q <= 1'b1;
         end
      end
   end

   assign req_addr     = addr_q;
   assign req_data     = DW_EFF'(w_rdata.data);
   assign req_strb     = SW_EFF'(w_rdata.strb);
   assign b_wdata.id   = NASTI_ID_W'(id_q);
   assign b_wdata.resp = err_q ? RESP_SLVERR : RESP_OKAY;
   assign b_wdata.user = NASTI_USER_W'(user_q);

endmodule
